if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the RV32I core, directly upstream of the control unit.
//  Owns the PC and runs the instruction-memory request/ready handshake.
//  Drives the IF/ID pipeline register; ifid_opcode (instr[6:2]) feeds the control unit's opcode input.
//  Handles branch redirect, flush and stall, with a one-entry hold buffer so no fetched word is lost.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 PC value after reset
//  NOP_INSTR 32'h0000_0013 bubble instruction (addi x0,x0,0)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  imem_req       out  1     fetch request valid
//  imem_addr      out  XLEN  fetch address; word aligned
//  imem_ready     in   1     imem_rdata valid this cycle; completes the request
//  imem_rdata     in   32    fetched instruction word
//  stall          in   1     hold IF/ID and PC (hazard unit)
//  flush          in   1     invalidate IF/ID; refetch current PC
//  branch_taken   in   1     redirect fetch to branch_target; implies flush
//  branch_target  in   XLEN  redirect address; bits [1:0] ignored (forced 00)
//  ifid_valid     out  1     IF/ID holds a real instruction
//  ifid_pc        out  XLEN  PC of ifid_instr
//  ifid_instr     out  32    instruction to decode
//  ifid_opcode    out  5     ifid_instr[6:2], to control unit
//  perf_fetch_cnt out  32    instructions delivered (IF_PERF_CNT_EN)
//  perf_bubble_cnt out 32    cycles with ifid_valid=0 (IF_PERF_CNT_EN)
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, req_addr=RESET_PC, state=REQ, ifid_valid=0,
//   ifid_pc=0, ifid_instr=NOP_INSTR, counters=0. imem_req low only while rst is high.
//  Priority each cycle: rst > branch_taken > flush > stall > normal.
//  Handshake: imem_req=1 in REQ and DROP. imem_addr=req_addr.
//   The address is stable while req && !ready; one request in flight max. Zero-wait ready is legal.
//  States:
//   REQ : when ready && no redirect && !stall: IF/ID <= {1, req_addr, rdata}; pc,req_addr += 4.
//         when ready && stall: hold_buf <= rdata -> HOLD.
//         when !ready && !stall: IF/ID <= bubble. When stall: IF/ID holds.
//   HOLD: imem_req=0. When !stall: IF/ID <= {1, pc, hold_buf}; pc,req_addr += 4 -> REQ.
//   DROP: request outstanding that must be discarded. When ready: drop rdata -> REQ, fetch req_addr.
//  Redirect (branch_taken; flush uses target=pc):
//   IF/ID <= bubble (valid=0, instr=NOP_INSTR) even if stall=1. pc <= {target[31:2],2'b00}.
//   In REQ && ready, or in HOLD: req_addr <= new pc; hold_buf discarded -> REQ.
//   In REQ && !ready: req_addr is kept -> DROP; req_addr <= new pc when the drop completes.
//   In DROP: pc updated; still DROP.
//  Bubble: ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc keeps its last value.
//  Arithmetic: PC += 4 mod 2^XLEN; wraps from 32'hFFFF_FFFC to 0 silently.
//  Latency: a response accepted at edge N shows on ifid_* after edge N; 1 instr/cycle sustained.
//  ifid_opcode is purely combinational from ifid_instr[6:2].
// CONFIGURATION
//  IF_PERF_CNT_EN defined: perf_fetch_cnt +1 per IF/ID load with valid=1.
//   perf_bubble_cnt +1 per cycle with ifid_valid=0 after reset. Both wrap at 2^32 and reset to 0.
//  Not defined: no counter flops; both ports tied to 32'h0. All other behaviour identical.
// TESTING
//  T1 reset: rst=1 mid-fetch -> imem_req=0, ifid_valid=0, ifid_instr=32'h13.
//     After release: imem_addr=0, ifid_opcode=5'b00100.
//  T2 stream: ready=1 every cycle, rdata=0x00000033/0x00002003/0x00802023/0x00000063.
//     -> ifid_pc 0,4,8,C; ifid_opcode 01100,00000,01000,11000 on consecutive cycles.
//  T3 stall: stall=1 for 3 cycles at pc=8 with ready=1 -> HOLD, imem_req=0, IF/ID frozen.
//     On release -> ifid_pc=8 with the buffered word; no word lost or duplicated.
//  T4 redirect in flight: branch_taken, target=0x103 while ready=0 at req_addr=0x10.
//     -> state DROP, late response discarded; next fetch addr=0x100, ifid_valid=0 meanwhile.
//  T5 flush+stall together: flush=1 with stall=1 -> ifid_valid=0 next cycle; refetch same pc.
//  T6 wrap/perf: pc=32'hFFFF_FFFC, ready=1 -> next imem_addr=0.
//     With IF_PERF_CNT_EN: after T2, perf_fetch_cnt=4.

Source files
------------

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, imem request/ready handshake, IF/ID register, one-entry hold buffer.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic [4:0]      ifid_opcode,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] req_addr, req_addr_nxt;
    logic [31:0]     hold_buf, hold_nxt;
    logic            valid_nxt;
    logic [XLEN-1:0] ifid_pc_nxt;
    logic [31:0]     instr_nxt;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;

    // A flush is a redirect to the current PC; a branch overrides it.
    assign redirect = branch_taken | flush;
    assign target   = branch_taken ? {branch_target[XLEN-1:2], 2'b00} : pc;
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        hold_nxt     = hold_buf;
        valid_nxt    = ifid_valid;
        ifid_pc_nxt  = ifid_pc;
        instr_nxt    = ifid_instr;
        if (redirect) begin
            valid_nxt = 1'b0;
            instr_nxt = NOP_INSTR;
            pc_nxt    = target;
            // An unanswered request must still be drained before refetching.
            if (state == S_HOLD || imem_ready) begin
                req_addr_nxt = target;
                state_nxt    = S_REQ;
            end else begin
                state_nxt = S_DROP;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready && !stall) begin
                        valid_nxt    = 1'b1;
                        ifid_pc_nxt  = req_addr;
                        instr_nxt    = imem_rdata;
                        pc_nxt       = pc_plus4;
                        req_addr_nxt = pc_plus4;
                    end else if (imem_ready) begin
                        hold_nxt  = imem_rdata;
                        state_nxt = S_HOLD;
                    end else if (!stall) begin
                        valid_nxt = 1'b0;
                        instr_nxt = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        valid_nxt    = 1'b1;
                        ifid_pc_nxt  = pc;
                        instr_nxt    = hold_buf;
                        pc_nxt       = pc_plus4;
                        req_addr_nxt = pc_plus4;
                        state_nxt    = S_REQ;
                    end
                end
                default: begin
                    if (!stall) begin
                        valid_nxt = 1'b0;
                        instr_nxt = NOP_INSTR;
                    end
                    if (imem_ready) begin
                        req_addr_nxt = pc;
                        state_nxt    = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_buf   <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            req_addr   <= req_addr_nxt;
            hold_buf   <= hold_nxt;
            ifid_valid <= valid_nxt;
            ifid_pc    <= ifid_pc_nxt;
            ifid_instr <= instr_nxt;
        end
    end

    assign imem_req    = !rst && (state != S_HOLD);
    assign imem_addr   = req_addr;
    assign ifid_opcode = ifid_instr[6:2];
    assign dbg_state   = state;

`ifdef IF_PERF_CNT_EN
    logic fetch_evt;
    // A valid next IF/ID while the register actually changes content means a new delivery.
    assign fetch_evt = valid_nxt && (instr_nxt != ifid_instr || ifid_pc_nxt != ifid_pc || !ifid_valid)
                       && !(state == S_REQ && !imem_ready) && !(state == S_HOLD && stall)
                       && !(state == S_REQ && stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            perf_fetch_cnt  <= perf_fetch_cnt + {31'd0, fetch_evt};
            perf_bubble_cnt <= perf_bubble_cnt + {31'd0, !ifid_valid};
        end
    end
`else
    assign perf_fetch_cnt  = 32'h0;
    assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: reset, streaming, stall/hold, in-flight redirect, flush, PC wrap.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [4:0]  ifid_opcode;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_opcode(ifid_opcode),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        fl;
        logic        br;
        logic [31:0] tgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [1:0]  est;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic [31:0] rdata, input logic stl, input logic fl,
                       input logic br, input logic [31:0] tgt, input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                       input logic [1:0] est);
        vec_t v;
        v = '{rdy, rdata, stl, fl, br, tgt, ereq, eaddr, ev, epc, einstr, est};
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
        flush = 1'b0; branch_taken = 1'b0; branch_target = '0;

        //      rdy rdata         stl fl br tgt           req addr          v  pc            instr         state
        // streaming
        add(1, 32'h0000_0033, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0033, ST_REQ);
        add(1, 32'h0000_2003, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0004, 32'h0000_2003, ST_REQ);
        add(1, 32'h0080_2023, 0, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0008, 32'h0080_2023, ST_REQ);
        add(1, 32'h0000_0063, 0, 0, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_000C, 32'h0000_0063, ST_REQ);
        // stall with ready -> hold buffer, then release
        add(1, 32'h0010_0093, 1, 0, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0063, ST_HOLD);
        add(0, 32'h0,         1, 0, 0, 32'h0,         0, 32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0063, ST_HOLD);
        add(0, 32'h0,         1, 0, 0, 32'h0,         0, 32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0063, ST_HOLD);
        add(0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0000_0010, 1, 32'h0000_0010, 32'h0010_0093, ST_REQ);
        add(1, 32'h0020_0113, 0, 0, 0, 32'h0,         1, 32'h0000_0014, 1, 32'h0000_0014, 32'h0020_0113, ST_REQ);
        // wait state, then branch while the request is outstanding
        add(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_0018, 0, 32'h0000_0014, NOP,           ST_REQ);
        add(0, 32'h0,         0, 0, 1, 32'h0000_0103, 1, 32'h0000_0018, 0, 32'h0000_0014, NOP,           ST_DROP);
        add(0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_0018, 0, 32'h0000_0014, NOP,           ST_DROP);
        add(1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         1, 32'h0000_0018, 0, 32'h0000_0014, NOP,           ST_REQ);
        add(1, 32'h0030_0193, 0, 0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0100, 32'h0030_0193, ST_REQ);
        // flush together with stall, then refetch of the same pc
        add(1, 32'h0040_0213, 1, 1, 0, 32'h0,         1, 32'h0000_0104, 0, 32'h0000_0100, NOP,           ST_REQ);
        add(1, 32'h0040_0213, 0, 0, 0, 32'h0,         1, 32'h0000_0104, 1, 32'h0000_0104, 32'h0040_0213, ST_REQ);
        // flush while holding discards the buffered word
        add(1, 32'h0050_0293, 1, 0, 0, 32'h0,         1, 32'h0000_0108, 1, 32'h0000_0104, 32'h0040_0213, ST_HOLD);
        add(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0000_0108, 0, 32'h0000_0104, NOP,           ST_REQ);
        add(1, 32'h0050_0293, 0, 0, 0, 32'h0,         1, 32'h0000_0108, 1, 32'h0000_0108, 32'h0050_0293, ST_REQ);
        // branch to the top word (low bits ignored), then wrap to 0
        add(1, 32'h0000_006F, 0, 0, 1, 32'hFFFF_FFFE, 1, 32'h0000_010C, 0, 32'h0000_0108, NOP,           ST_REQ);
        add(1, 32'h0060_0313, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0060_0313, ST_REQ);
        add(1, 32'h0070_0393, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0000_0000, 32'h0070_0393, ST_REQ);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_instr", ifid_instr, NOP);
        check("rst_pc", ifid_pc, 32'd0);
        check("rst_fetch_cnt", perf_fetch_cnt, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'd0);
        check("rel_opcode", {27'd0, ifid_opcode}, 32'h04);
        check("rel_state", {30'd0, dbg_state}, {30'd0, ST_REQ});

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            @(negedge clk);
            imem_ready = v.rdy; imem_rdata = v.rdata; stall = v.stl;
            flush = v.fl; branch_taken = v.br; branch_target = v.tgt;
            #1;
            check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, v.ereq});
            if (v.ereq) check($sformatf("v%0d_addr", i), imem_addr, v.eaddr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, v.ev});
            check($sformatf("v%0d_pc", i), ifid_pc, v.epc);
            check($sformatf("v%0d_instr", i), ifid_instr, v.einstr);
            check($sformatf("v%0d_opcode", i), {27'd0, ifid_opcode}, {27'd0, v.einstr[6:2]});
            check($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, v.est});
            if (i == 3) begin
`ifdef IF_PERF_CNT_EN
                check("perf_fetch_after_stream", perf_fetch_cnt, 32'd4);
`else
                check("perf_fetch_tied", perf_fetch_cnt, 32'd0);
                check("perf_bubble_tied", perf_bubble_cnt, 32'd0);
`endif
            end
        end

        // asynchronous reset in the middle of a cycle with a request outstanding
        imem_ready = 1'b0; imem_rdata = '0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("async_rst_instr", ifid_instr, NOP);
        check("async_rst_addr", imem_addr, 32'd0);
        check("async_rst_fetch_cnt", perf_fetch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rel_req", {31'd0, imem_req}, 32'd1);
        check("async_rel_addr", imem_addr, 32'd0);
        check("async_rel_opcode", {27'd0, ifid_opcode}, 32'h04);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, ifid_valid}, 32'd1);
        check("post_rst_pc", ifid_pc, 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_next_addr", imem_addr, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
